sd_clk_rate_generator: RTL and testbench
========================================

# sd_clk_rate_generator

Parametrised SD-card clock generator for the host controller: decodes the CSD TRAN_SPEED byte (or selects the fixed identification rate) and computes the SD clock half-period with an internal sequential divider. It then generates a glitch-free, gateable SD clock with edge strobes for the command and data paths. Sits between the CSD/register front end and the CMD/DAT line engines.

## Interface
- SYS_CLK_HZ, 50_000_000, system clock frequency in Hz.
- CNT_W, 16, width of the half-period count; must hold ceil(SYS_CLK_HZ/(2*ID_RATE_HZ)).
- ID_RATE_HZ, 400_000, identification-mode SD clock rate in Hz.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to compute a new rate; ignored while busy.
- mode  in  1  0 = identification rate (ID_RATE_HZ), 1 = decode tran_speed.
- tran_speed  in  8  CSD TRAN_SPEED byte; sampled with start.
- clk_en  in  1  1 = run sd_clk, 0 = park sd_clk low.
- busy  out  1  rate computation in progress.
- ok  out  1  one-cycle pulse: new half_period accepted.
- err  out  1  one-cycle pulse: request rejected; half_period unchanged.
- half_period  out  CNT_W  active half-period in clk cycles (>= 1).
- sd_clk  out  1  generated SD clock, registered.
- sd_clk_rise / sd_clk_fall  out  1 each  one-cycle strobes in the clk cycle sd_clk goes 1 / 0.

## Operation
- Rate decode (mode=1): mantissa tran_speed[6:3] 1..F -> 10,12,13,15,20,25,30,35,40,45,50,55,60,70,80; unit tran_speed[2:0] 0..3 -> 10_000, 100_000, 1_000_000, 10_000_000; rate = mantissa*unit (32 bit). Mantissa 0 or unit 4..7 -> err. tran_speed[7] ignored.
- mode=0: rate = ID_RATE_HZ, tran_speed ignored.
- Half-period = ceil(SYS_CLK_HZ / (2*rate)), so the delivered rate never exceeds the requested rate. Quotient computed by a 32-iteration restoring divider (32-bit dividend, 32-bit divisor 2*rate). Round up when remainder != 0. Result of 0 is impossible; result > 2^CNT_W-1 -> err.
- FSM: IDLE -(start)-> LOAD (latch inputs, decode; invalid -> ERR) -> DIV (32 cycles) -> CHECK (round, range check) -> ACCEPT or ERR -> IDLE. ACCEPT asserts ok and loads pending_half; ERR asserts err. busy = state != IDLE.
- start while busy: ignored, no pulse.
- Clock engine: counter runs 0..cur_half-1 while clk_en=1 or sd_clk=1. At terminal count, sd_clk toggles, counter clears, and the matching strobe fires.
- Rate switching: a newly accepted half_period becomes cur_half only at the next toggle (or immediately when parked). The current phase always completes at the old length. half_period output reports the accepted value.
- clk_en falling while sd_clk=1: the high phase completes, then sd_clk stays low. While parked, the counter holds 0.
- clk_en rising while parked: first rise after cur_half cycles.

## Timing
- Reset values: state IDLE, busy 0, ok 0, err 0, sd_clk 0, strobes 0, counter 0, half_period = cur_half = ceil(SYS_CLK_HZ/(2*ID_RATE_HZ)) (63 at defaults).
- Latency: start sampled at edge N -> busy from N+1 -> ok/err high for cycle N+35..N+36 (LOAD 1, DIV 32, CHECK 1, pulse 1). Decode error -> err at N+2.
- busy drops in the same edge that ok/err rises. A new start is accepted in the ok/err cycle.
- Strobes are coincident with the sd_clk register change.
- Reset asserted mid-computation or mid-phase: immediate return to reset values. No partial result is applied.
- sd_clk period = 2*cur_half clk cycles, 50% duty. No phase shorter than min(old, new) half-period is ever produced.

## Test plan
- Reset, clk_en=1, no start -> half_period=63; sd_clk toggles every 63 clks (396.8 kHz); first rise 63 clks after clk_en.
- mode=1, tran_speed=0x32 (25 MHz) -> ok 35 clks after start, half_period=1; sd_clk toggles every clk. Switch applied at the next toggle, with no short phase.
- tran_speed=0x2A (20 MHz) -> half_period=2 (12.5 MHz); tran_speed=0x0B (100 MHz) -> half_period=1.
- tran_speed=0x36 and 0x02 -> err at start+2, half_period unchanged, sd_clk undisturbed. Second start during busy -> ignored.
- CNT_W=6, tran_speed=0x08 (100 kHz, quotient 250) -> err at start+35, half_period stays 63.
- clk_en dropped mid-high -> high phase completes, sd_clk parks low. Reset asserted mid-DIV -> busy=0, sd_clk=0, half_period=63 immediately.

Source files
------------

// File: rtl/sd_clk_rate_generator_if.sv
// sd_clk_rate_generator_if
// Bundles the rate-request handshake and the generated SD clock into one port.
//   master (register front end / line engines):
//     drives  start, mode, tran_speed, clk_en
//     reads   busy, ok, err, half_period, sd_clk, sd_clk_rise, sd_clk_fall
//   slave (sd_clk_rate_generator): the opposite directions.
interface sd_clk_rate_generator_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             mode;
    logic [7:0]       tran_speed;
    logic             clk_en;
    logic             busy;
    logic             ok;
    logic             err;
    logic [CNT_W-1:0] half_period;
    logic             sd_clk;
    logic             sd_clk_rise;
    logic             sd_clk_fall;

    modport master (
        output start, mode, tran_speed, clk_en,
        input  busy, ok, err, half_period, sd_clk, sd_clk_rise, sd_clk_fall
    );

    modport slave (
        input  start, mode, tran_speed, clk_en,
        output busy, ok, err, half_period, sd_clk, sd_clk_rise, sd_clk_fall
    );
endinterface

// File: rtl/sd_clk_rate_generator.sv
// sd_clk_rate_generator
// Turns a CSD TRAN_SPEED byte (or the fixed identification rate) into an SD
// clock half-period using a 32-step restoring divider, then generates a
// registered, gateable SD clock with one-cycle rise/fall strobes.
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  asynchronous, active-low reset
//   bus    slave side of sd_clk_rate_generator_if:
//          start/mode/tran_speed  rate request (start ignored while busy)
//          clk_en                 run (1) or park low (0) the SD clock
//          busy/ok/err            computation status and result pulses
//          half_period            accepted half-period in clk cycles
//          sd_clk, sd_clk_rise/fall  generated clock and edge strobes
module sd_clk_rate_generator #(
    parameter int SYS_CLK_HZ = 50_000_000,
    parameter int CNT_W      = 16,
    parameter int ID_RATE_HZ = 400_000
) (
    input  logic                    clk,
    input  logic                    reset,
    sd_clk_rate_generator_if.slave  bus
);

    localparam int               ID_HALF_INT = (SYS_CLK_HZ + 2 * ID_RATE_HZ - 1) / (2 * ID_RATE_HZ);
    localparam logic [CNT_W-1:0] ID_HALF     = CNT_W'(ID_HALF_INT);
    localparam logic [31:0]      DIVIDEND    = 32'(SYS_CLK_HZ);
    localparam logic [31:0]      ID_DIVISOR  = 32'(2 * ID_RATE_HZ);
    localparam logic [32:0]      HALF_MAX    = (33'd1 << CNT_W) - 33'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_CHECK,
        S_ACCEPT,
        S_ERR
    } state_t;

    // Mantissa codes scaled by 10; code 0 is reserved and returns 0.
    function automatic logic [31:0] mantissa_x10(input logic [3:0] code);
        logic [31:0] m;
        case (code)
            4'h1:    m = 32'd10;
            4'h2:    m = 32'd12;
            4'h3:    m = 32'd13;
            4'h4:    m = 32'd15;
            4'h5:    m = 32'd20;
            4'h6:    m = 32'd25;
            4'h7:    m = 32'd30;
            4'h8:    m = 32'd35;
            4'h9:    m = 32'd40;
            4'hA:    m = 32'd45;
            4'hB:    m = 32'd50;
            4'hC:    m = 32'd55;
            4'hD:    m = 32'd60;
            4'hE:    m = 32'd70;
            4'hF:    m = 32'd80;
            default: m = 32'd0;
        endcase
        return m;
    endfunction

    // Unit multiplier already divided by 10 to match the scaled mantissa.
    function automatic logic [31:0] unit_hz(input logic [1:0] code);
        logic [31:0] u;
        case (code)
            2'd0:    u = 32'd10_000;
            2'd1:    u = 32'd100_000;
            2'd2:    u = 32'd1_000_000;
            default: u = 32'd10_000_000;
        endcase
        return u;
    endfunction

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [6:0]       speed_q, speed_d;
    logic [31:0]      divisor_q, divisor_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rem_q, rem_d;
    logic [4:0]       iter_q, iter_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;

    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sd_clk_q, sd_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic             load_pending;
    logic [31:0]      mant_val;
    logic [31:0]      rate;
    logic [31:0]      rem_shift;
    logic [32:0]      rounded;

    // Request sequencer and divider datapath. ACCEPT/ERR behave like IDLE for
    // a new start so back-to-back requests lose no cycle.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        speed_d       = speed_q;
        divisor_d     = divisor_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        iter_d        = iter_q;
        half_period_d = half_period_q;
        load_pending  = 1'b0;
        mant_val      = mantissa_x10(speed_q[6:3]);
        rate          = mant_val * unit_hz(speed_q[1:0]);
        rem_shift     = {rem_q[30:0], quo_q[31]};
        rounded       = {1'b0, quo_q} + {32'd0, |rem_q};

        case (state_q)
            S_IDLE, S_ACCEPT, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    mode_d  = bus.mode;
                    speed_d = bus.tran_speed[6:0];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                quo_d  = DIVIDEND;
                rem_d  = 32'd0;
                iter_d = 5'd0;
                if (!mode_q) begin
                    divisor_d = ID_DIVISOR;
                    state_d   = S_DIV;
                end else if (mant_val == 32'd0 || speed_q[2]) begin
                    state_d = S_ERR;
                end else begin
                    divisor_d = {rate[30:0], 1'b0};
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                // One restoring step: shift the next dividend bit into the
                // remainder, subtract when it fits, record the quotient bit.
                if (rem_shift >= divisor_q) begin
                    rem_d = rem_shift - divisor_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    quo_d = {quo_q[30:0], 1'b0};
                end
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Rounding up keeps the delivered rate at or below the request.
                if (rounded > HALF_MAX) begin
                    state_d = S_ERR;
                end else begin
                    state_d       = S_ACCEPT;
                    half_period_d = rounded[CNT_W-1:0];
                    load_pending  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            speed_q       <= 7'd0;
            divisor_q     <= 32'd0;
            quo_q         <= 32'd0;
            rem_q         <= 32'd0;
            iter_q        <= 5'd0;
            half_period_q <= ID_HALF;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            speed_q       <= speed_d;
            divisor_q     <= divisor_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            iter_q        <= iter_d;
            half_period_q <= half_period_d;
        end
    end

    // Clock engine. A new half-period waits in pending until the next toggle
    // (or is taken at once while parked) so no phase is ever cut short.
    // The counter keeps running while sd_clk is high so a gated-off high
    // phase still completes before parking low.
    always_comb begin
        cnt_d           = cnt_q;
        sd_clk_d        = sd_clk_q;
        rise_d          = 1'b0;
        fall_d          = 1'b0;
        cur_half_d      = cur_half_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;

        if (bus.clk_en || sd_clk_q) begin
            if (cnt_q == cur_half_q - CNT_W'(1)) begin
                sd_clk_d = ~sd_clk_q;
                cnt_d    = '0;
                rise_d   = ~sd_clk_q;
                fall_d   = sd_clk_q;
                if (pending_valid_q) begin
                    cur_half_d      = pending_q;
                    pending_valid_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
            if (pending_valid_q) begin
                cur_half_d      = pending_q;
                pending_valid_d = 1'b0;
            end
        end

        if (load_pending) begin
            pending_d       = half_period_d;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q           <= '0;
            sd_clk_q        <= 1'b0;
            rise_q          <= 1'b0;
            fall_q          <= 1'b0;
            cur_half_q      <= ID_HALF;
            pending_q       <= ID_HALF;
            pending_valid_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            sd_clk_q        <= sd_clk_d;
            rise_q          <= rise_d;
            fall_q          <= fall_d;
            cur_half_q      <= cur_half_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    // busy covers only the working states; it drops as ok/err rises.
    assign bus.busy        = (state_q == S_LOAD) || (state_q == S_DIV) || (state_q == S_CHECK);
    assign bus.ok          = (state_q == S_ACCEPT);
    assign bus.err         = (state_q == S_ERR);
    assign bus.half_period = half_period_q;
    assign bus.sd_clk      = sd_clk_q;
    assign bus.sd_clk_rise = rise_q;
    assign bus.sd_clk_fall = fall_q;

endmodule

// File: tb/tb_sd_clk_rate_generator.sv
// tb_sd_clk_rate_generator
// Directed bench for sd_clk_rate_generator: one instance at default width
// and one with CNT_W=6 to reach the range-overflow error.
module tb_sd_clk_rate_generator;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sd_clk_rate_generator_if #(.CNT_W(16)) bus16 ();
    sd_clk_rate_generator_if #(.CNT_W(6))  bus6 ();

    sd_clk_rate_generator #(
        .SYS_CLK_HZ(50_000_000),
        .CNT_W     (16),
        .ID_RATE_HZ(400_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus16.slave)
    );

    sd_clk_rate_generator #(
        .SYS_CLK_HZ(50_000_000),
        .CNT_W     (6),
        .ID_RATE_HZ(400_000)
    ) dut6 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus6.slave)
    );

    int          assertCount = 0;
    int          failCount   = 0;
    int          phaseCnt    = 0;
    int          lastPhase   = 0;
    bit          tbSel       = 1'b0;
    int          cyc;
    bit          bad;

    logic        obsBusy;
    logic        obsOk;
    logic        obsErr;
    logic [31:0] obsHalf;

    assign obsBusy = tbSel ? bus6.busy : bus16.busy;
    assign obsOk   = tbSel ? bus6.ok   : bus16.ok;
    assign obsErr  = tbSel ? bus6.err  : bus16.err;
    assign obsHalf = tbSel ? 32'(bus6.half_period) : 32'(bus16.half_period);

    // Phase-length monitor for the 16-bit instance: lastPhase holds the
    // length in clk cycles of the sd_clk phase that just ended.
    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            phaseCnt = 0;
        end else if (bus16.sd_clk_rise || bus16.sd_clk_fall) begin
            lastPhase = phaseCnt + 1;
            phaseCnt  = 0;
        end else begin
            phaseCnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse on the selected instance; returns after the
    // edge that samples it.
    task automatic applyStimulus(input bit sel, input logic m, input logic [7:0] ts);
        tbSel = sel;
        if (sel) begin
            bus6.mode = m; bus6.tran_speed = ts; bus6.start = 1'b1;
        end else begin
            bus16.mode = m; bus16.tran_speed = ts; bus16.start = 1'b1;
        end
        tick(1);
        bus6.start  = 1'b0;
        bus16.start = 1'b0;
    endtask

    // kind: 0 any edge, 1 rise, 2 fall. cycles = -1 when the bound expires.
    task automatic waitStrobe(input int kind, input int maxCycles, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < maxCycles) begin
            tick(1);
            cycles++;
            case (kind)
                1:       hit = bus16.sd_clk_rise;
                2:       hit = bus16.sd_clk_fall;
                default: hit = bus16.sd_clk_rise | bus16.sd_clk_fall;
            endcase
        end
        if (!hit) cycles = -1;
    endtask

    // Issues a request and checks busy, the pulse cycle (lat cycles after
    // the start cycle), the reported half-period and the pulse width.
    task automatic runRequest(input bit sel, input logic m, input logic [7:0] ts, input int lat,
                              input bit expOk, input logic [31:0] expHalf, input bit inject,
                              input string tag);
        bit quiet;
        quiet = 1'b0;
        applyStimulus(sel, m, ts);
        checkOutput({tag, "_busy"}, 32'(obsBusy), 32'd1);
        for (int i = 2; i < lat; i++) begin
            if (inject && i == 4) begin
                bus16.mode = 1'b1; bus16.tran_speed = 8'h36; bus16.start = 1'b1;
            end else begin
                bus16.start = 1'b0;
            end
            tick(1);
            if (obsOk || obsErr) quiet = 1'b1;
        end
        bus16.start = 1'b0;
        if (lat > 2) checkOutput({tag, "_early_pulse"}, 32'(quiet), 32'd0);
        tick(1);
        checkOutput({tag, "_ok"},     32'(obsOk),   32'(expOk));
        checkOutput({tag, "_err"},    32'(obsErr),  32'(!expOk));
        checkOutput({tag, "_idle"},   32'(obsBusy), 32'd0);
        checkOutput({tag, "_half"},   obsHalf,      expHalf);
        tick(1);
        checkOutput({tag, "_pulse_end"}, 32'({obsOk, obsErr}), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.tran_speed = 8'h00; bus16.clk_en = 1'b0;
        bus6.start  = 1'b0; bus6.mode  = 1'b0; bus6.tran_speed  = 8'h00; bus6.clk_en  = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);

        $display("[TB] reset values");
        checkOutput("rst_busy",   32'(bus16.busy),        32'd0);
        checkOutput("rst_ok",     32'(bus16.ok),          32'd0);
        checkOutput("rst_err",    32'(bus16.err),         32'd0);
        checkOutput("rst_sd_clk", 32'(bus16.sd_clk),      32'd0);
        checkOutput("rst_rise",   32'(bus16.sd_clk_rise), 32'd0);
        checkOutput("rst_half",   32'(bus16.half_period), 32'd63);
        checkOutput("rst_half6",  32'(bus6.half_period),  32'd63);

        $display("[TB] identification rate running");
        bus16.clk_en = 1'b1;
        waitStrobe(1, 200, cyc);
        checkOutput("first_rise_cycles", 32'(cyc), 32'd63);
        checkOutput("first_rise_level",  32'(bus16.sd_clk), 32'd1);
        waitStrobe(2, 200, cyc);
        checkOutput("first_fall_cycles", 32'(cyc), 32'd63);
        checkOutput("first_fall_level",  32'(bus16.sd_clk), 32'd0);
        checkOutput("id_phase", 32'(lastPhase), 32'd63);

        $display("[TB] 25 MHz request with ignored start while busy");
        runRequest(1'b0, 1'b1, 8'h32, 35, 1'b1, 32'd1, 1'b1, "r25");
        waitStrobe(1, 100, cyc);
        checkOutput("r25_rise_wait", 32'(cyc), 32'd27);
        checkOutput("r25_old_phase", 32'(lastPhase), 32'd63);
        waitStrobe(2, 10, cyc);
        checkOutput("r25_fall_wait", 32'(cyc), 32'd1);
        checkOutput("r25_new_phase", 32'(lastPhase), 32'd1);

        $display("[TB] 20 MHz request");
        runRequest(1'b0, 1'b1, 8'h2A, 35, 1'b1, 32'd2, 1'b0, "r20");
        waitStrobe(0, 10, cyc);
        waitStrobe(0, 10, cyc);
        checkOutput("r20_wait",  32'(cyc), 32'd2);
        checkOutput("r20_phase", 32'(lastPhase), 32'd2);

        $display("[TB] 100 MHz request");
        runRequest(1'b0, 1'b1, 8'h0B, 35, 1'b1, 32'd1, 1'b0, "r100");
        waitStrobe(0, 10, cyc);
        waitStrobe(0, 10, cyc);
        checkOutput("r100_wait",  32'(cyc), 32'd1);
        checkOutput("r100_phase", 32'(lastPhase), 32'd1);

        $display("[TB] decode errors");
        runRequest(1'b0, 1'b1, 8'h36, 2, 1'b0, 32'd1, 1'b0, "bad_unit");
        runRequest(1'b0, 1'b1, 8'h02, 2, 1'b0, 32'd1, 1'b0, "bad_mant");
        waitStrobe(0, 10, cyc);
        checkOutput("err_clk_undisturbed", 32'(cyc), 32'd1);

        $display("[TB] reset during divide");
        applyStimulus(1'b0, 1'b1, 8'h2A);
        tick(10);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_busy",   32'(bus16.busy),        32'd0);
        checkOutput("mid_rst_sd_clk", 32'(bus16.sd_clk),      32'd0);
        checkOutput("mid_rst_half",   32'(bus16.half_period), 32'd63);
        tick(2);
        reset = 1'b1;
        tick(2);

        $display("[TB] identification mode request and gating");
        runRequest(1'b0, 1'b0, 8'h0B, 35, 1'b1, 32'd63, 1'b0, "rid");
        waitStrobe(1, 200, cyc);
        tick(10);
        bus16.clk_en = 1'b0;
        waitStrobe(2, 100, cyc);
        checkOutput("gate_fall_wait", 32'(cyc), 32'd53);
        checkOutput("gate_high_phase", 32'(lastPhase), 32'd63);
        bad = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (bus16.sd_clk || bus16.sd_clk_rise) bad = 1'b1;
        end
        checkOutput("parked_low", 32'(bad), 32'd0);
        bus16.clk_en = 1'b1;
        waitStrobe(1, 200, cyc);
        checkOutput("reenable_rise", 32'(cyc), 32'd63);

        $display("[TB] narrow counter instance");
        runRequest(1'b1, 1'b1, 8'h08, 35, 1'b0, 32'd63, 1'b0, "w6_ovf");
        runRequest(1'b1, 1'b1, 8'h32, 35, 1'b1, 32'd1, 1'b0, "w6_ok");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
